// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader for the toy CPU instruction memory.
//
// Accepts a framed byte stream (SYNC, LEN_HI, LEN_LO, LEN big-endian words,
// optional CSUM) over a valid/ready handshake.  Assembled words are written
// sequentially into instruction memory from address 0.  The CPU is held in
// reset from the first accepted SYNC until a complete, verified image lands.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   -> a trailing CSUM byte (XOR of all data bytes) is expected and
//                checked; mismatch reports err_code 2'b10.
//   undefined -> no CSUM byte; the load finishes after the last word.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous, active-low reset
//   in_data    in   received byte
//   in_valid   in   in_data valid
//   in_ready   out  loader can accept a byte (low only in FIN)
//   imem_we    out  instruction memory write strobe (one cycle per word)
//   imem_addr  out  write address (ADDR_W bits)
//   imem_wdata out  write data {hi_byte, lo_byte}
//   cpu_hold   out  1 holds the CPU in reset
//   done       out  one-cycle pulse on successful load
//   err        out  sticky error flag, cleared by the next accepted SYNC
//   err_code   out  01 length overflow, 10 checksum mismatch, 11 timeout
module prog_loader #(
  parameter int         ADDR_W  = 7,
  parameter int         TIMEOUT = 65535,
  parameter logic [7:0] SYNC    = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [15:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEN_H = 3'd1,
    LEN_L = 3'd2,
    DAT_H = 3'd3,
    DAT_L = 3'd4,
    CSUM  = 3'd5,
    FIN   = 3'd6
  } state_t;

  // Memory depth as a 17-bit value so it can be compared with a 16-bit LEN.
  localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

  function automatic logic [7:0] csumStep(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t            state;
  state_t            nextState;
  logic              inReadyR;
  logic [7:0]        lenHiR;
  logic [15:0]       lenR;
  logic [7:0]        dataHiR;
  logic [15:0]       wordCnt;
  logic [ADDR_W-1:0] addrCnt;
  logic [15:0]       idleCnt;

  logic              accept;
  logic [15:0]       lenWord;
  logic              lastWord;
  logic              counting;
  logic              timeoutHit;
  logic              startFrame;
  logic              doWrite;
  logic              doneSet;
  logic              setErr;
  logic [1:0]        errCodeSet;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csumR;
`endif

  assign accept     = in_valid & inReadyR;
  assign lenWord    = {lenHiR, in_data};
  assign lastWord   = ((wordCnt + 16'd1) == lenR);
  assign counting   = (state != IDLE) && (state != FIN);
  // An accepted byte always wins over an expiring idle count.
  assign timeoutHit = counting && !accept && (idleCnt == TIMEOUT_LAST);

  // Next-state and per-cycle control decode.
  always_comb begin
    nextState  = state;
    startFrame = 1'b0;
    doWrite    = 1'b0;
    doneSet    = 1'b0;
    setErr     = 1'b0;
    errCodeSet = 2'b00;
    case (state)
      IDLE: begin
        if (accept && (in_data == SYNC)) begin
          nextState  = LEN_H;
          startFrame = 1'b1;
        end else begin
          nextState = IDLE;
        end
      end
      LEN_H: begin
        if (accept) nextState = LEN_L;
        else        nextState = LEN_H;
      end
      LEN_L: begin
        if (!accept) begin
          nextState = LEN_L;
        end else if ({1'b0, lenWord} > DEPTH) begin
          nextState  = IDLE;
          setErr     = 1'b1;
          errCodeSet = 2'b01;
        end else if (lenWord == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
          nextState = CSUM;
`else
          nextState = FIN;
`endif
        end else begin
          nextState = DAT_H;
        end
      end
      DAT_H: begin
        if (accept) nextState = DAT_L;
        else        nextState = DAT_H;
      end
      DAT_L: begin
        if (accept) begin
          doWrite = 1'b1;
          if (lastWord) begin
`ifdef LOADER_CHECKSUM_EN
            nextState = CSUM;
`else
            nextState = FIN;
`endif
          end else begin
            nextState = DAT_H;
          end
        end else begin
          nextState = DAT_L;
        end
      end
      CSUM: begin
`ifdef LOADER_CHECKSUM_EN
        if (!accept) begin
          nextState = CSUM;
        end else if (in_data == csumR) begin
          nextState = FIN;
          doneSet   = 1'b1;
        end else begin
          nextState  = IDLE;
          setErr     = 1'b1;
          errCodeSet = 2'b10;
        end
`else
        nextState = IDLE;
`endif
      end
      FIN: begin
        nextState = IDLE;
`ifndef LOADER_CHECKSUM_EN
        // Without a checksum, FIN overlaps the last write strobe; finishing
        // one cycle later keeps done behind the final imem_we.
        doneSet = 1'b1;
`endif
      end
      default: begin
        nextState = IDLE;
      end
    endcase
    if (timeoutHit) begin
      nextState  = IDLE;
      setErr     = 1'b1;
      errCodeSet = 2'b11;
    end else begin
      nextState = nextState;
    end
  end

  // State, frame bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      inReadyR   <= 1'b1;
      lenHiR     <= 8'h00;
      lenR       <= 16'h0000;
      dataHiR    <= 8'h00;
      wordCnt    <= 16'h0000;
      addrCnt    <= '0;
      idleCnt    <= 16'h0000;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'h0000;
      cpu_hold   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state    <= nextState;
      inReadyR <= (nextState != FIN);

      if (accept && (state == LEN_H)) lenHiR <= in_data;
      if (accept && (state == LEN_L)) lenR <= lenWord;
      if (accept && (state == DAT_H)) dataHiR <= in_data;

      if (startFrame) begin
        wordCnt <= 16'h0000;
        addrCnt <= '0;
      end else if (doWrite) begin
        wordCnt <= wordCnt + 16'd1;
        addrCnt <= addrCnt + 1'b1;
      end

      if (accept || !counting || timeoutHit) idleCnt <= 16'h0000;
      else                                   idleCnt <= idleCnt + 16'd1;

      // imem_addr follows the counter, so it shows the write address during
      // the strobe and the wrapped value once a full-depth load completes.
      imem_we   <= doWrite;
      imem_addr <= addrCnt;
      if (doWrite) imem_wdata <= {dataHiR, in_data};

      if (startFrame)   cpu_hold <= 1'b1;
      else if (doneSet) cpu_hold <= 1'b0;

      done <= doneSet;

      if (startFrame) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end else if (setErr) begin
        err      <= 1'b1;
        err_code <= errCodeSet;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of data bytes for the current frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csumR <= 8'h00;
    end else if (startFrame) begin
      csumR <= 8'h00;
    end else if (accept && ((state == DAT_H) || (state == DAT_L))) begin
      csumR <= csumStep(csumR, in_data);
    end
  end
`endif

  assign in_ready = inReadyR;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader (ADDR_W=7, TIMEOUT=16).
module tb_prog_loader;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        imem_we;
  logic [6:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int nChecks = 0;
  int nFails  = 0;
  int weCount = 0;
  int doneCount = 0;
  logic [6:0]  lastAddr = 7'd0;
  logic [15:0] memModel [128];
  logic [7:0]  csumAcc;

  prog_loader #(.ADDR_W(7), .TIMEOUT(16), .SYNC(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done),
    .err(err), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record memory writes and done pulses away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      weCount++;
      memModel[imem_addr] = imem_wdata;
      lastAddr = imem_addr;
    end
    if (done) doneCount++;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted.
  task automatic sendByte(input logic [7:0] b);
    int guard;
    guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) checkVal("ready_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic sendCsum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
    sendByte(b);
`else
    in_data = b;
`endif
  endtask

  task automatic clearStats();
    weCount = 0;
    doneCount = 0;
  endtask

  initial begin
    rst = 1'b0;
    in_data = 8'h00;
    in_valid = 1'b0;
    for (int i = 0; i < 128; i++) memModel[i] = 16'h0000;
    repeat (3) @(negedge clk);
    checkVal("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
    checkVal("rst_we", {31'd0, imem_we}, 32'd0);
    checkVal("rst_addr", {25'd0, imem_addr}, 32'd0);
    checkVal("rst_wdata", {16'd0, imem_wdata}, 32'd0);
    checkVal("rst_done", {31'd0, done}, 32'd0);
    checkVal("rst_err", {31'd0, err}, 32'd0);
    checkVal("rst_err_code", {30'd0, err_code}, 32'd0);
    checkVal("rst_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);

    // Two-word load with a good checksum.
    clearStats();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h12); sendByte(8'h34);
    checkVal("w0_we", {31'd0, imem_we}, 32'd1);
    checkVal("w0_addr", {25'd0, imem_addr}, 32'd0);
    checkVal("w0_data", {16'd0, imem_wdata}, 32'h1234);
    sendByte(8'hAB);
    checkVal("w0_we_one_cycle", {31'd0, imem_we}, 32'd0);
    sendByte(8'hCD);
    checkVal("w1_we", {31'd0, imem_we}, 32'd1);
    checkVal("w1_addr", {25'd0, imem_addr}, 32'd1);
    checkVal("w1_data", {16'd0, imem_wdata}, 32'hABCD);
`ifdef LOADER_CHECKSUM_EN
    sendByte(8'h40);
    checkVal("fin_ready", {31'd0, in_ready}, 32'd0);
    checkVal("fin_done", {31'd0, done}, 32'd1);
    checkVal("fin_hold", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk);
    checkVal("done_pulse_end", {31'd0, done}, 32'd0);
`else
    checkVal("fin_ready", {31'd0, in_ready}, 32'd0);
    checkVal("fin_done_early", {31'd0, done}, 32'd0);
    checkVal("fin_hold_early", {31'd0, cpu_hold}, 32'd1);
    @(negedge clk);
    checkVal("fin_done", {31'd0, done}, 32'd1);
    checkVal("fin_hold", {31'd0, cpu_hold}, 32'd0);
    @(negedge clk);
    checkVal("done_pulse_end", {31'd0, done}, 32'd0);
`endif
    repeat (2) @(negedge clk);
    checkVal("t1_we_count", weCount, 32'd2);
    checkVal("t1_done_count", doneCount, 32'd1);
    checkVal("t1_mem0", {16'd0, memModel[0]}, 32'h1234);
    checkVal("t1_mem1", {16'd0, memModel[1]}, 32'hABCD);
    checkVal("t1_err", {31'd0, err}, 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Same frame, bad checksum.
    clearStats();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h12); sendByte(8'h34); sendByte(8'hAB); sendByte(8'hCD);
    sendByte(8'h41);
    checkVal("t2_err", {31'd0, err}, 32'd1);
    checkVal("t2_err_code", {30'd0, err_code}, 32'd2);
    repeat (3) @(negedge clk);
    checkVal("t2_hold", {31'd0, cpu_hold}, 32'd1);
    checkVal("t2_we_count", weCount, 32'd2);
    checkVal("t2_done_count", doneCount, 32'd0);
`endif

    // Length overflow (129 words), then a good frame clears err.
    clearStats();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h81);
    checkVal("t3_err", {31'd0, err}, 32'd1);
    checkVal("t3_err_code", {30'd0, err_code}, 32'd1);
    checkVal("t3_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (2) @(negedge clk);
    checkVal("t3_err_sticky", {31'd0, err}, 32'd1);
    checkVal("t3_no_writes", weCount, 32'd0);
    sendByte(8'hA5);
    checkVal("t3_err_cleared", {31'd0, err}, 32'd0);
    checkVal("t3_code_cleared", {30'd0, err_code}, 32'd0);
    sendByte(8'h00); sendByte(8'h01); sendByte(8'hBE); sendByte(8'hEF);
    sendCsum(8'h51);
    repeat (3) @(negedge clk);
    checkVal("t3_mem0", {16'd0, memModel[0]}, 32'hBEEF);
    checkVal("t3_done_count", doneCount, 32'd1);
    checkVal("t3_hold_low", {31'd0, cpu_hold}, 32'd0);

    // Timeout after 16 idle cycles inside a frame.
    clearStats();
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01); sendByte(8'h12);
    repeat (15) @(negedge clk);
    checkVal("t4_no_err_yet", {31'd0, err}, 32'd0);
    @(negedge clk);
    checkVal("t4_err", {31'd0, err}, 32'd1);
    checkVal("t4_err_code", {30'd0, err_code}, 32'd3);
    checkVal("t4_hold", {31'd0, cpu_hold}, 32'd1);
    checkVal("t4_ready", {31'd0, in_ready}, 32'd1);
    // Back in IDLE: a zero-length frame completes at once.
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h00);
    sendCsum(8'h00);
    repeat (3) @(negedge clk);
    checkVal("t4_len0_done", doneCount, 32'd1);
    checkVal("t4_len0_no_we", weCount, 32'd0);
    checkVal("t4_len0_err", {31'd0, err}, 32'd0);

    // Full 128-word load.
    clearStats();
    csumAcc = 8'h00;
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h80);
    for (int i = 0; i < 128; i++) begin
      sendByte(8'(i));
      sendByte(~8'(i));
      csumAcc = csumAcc ^ 8'(i) ^ ~8'(i);
    end
    sendCsum(csumAcc);
    repeat (3) @(negedge clk);
    checkVal("t5_we_count", weCount, 32'd128);
    checkVal("t5_last_addr", {25'd0, lastAddr}, 32'h7F);
    checkVal("t5_mem127", {16'd0, memModel[127]}, 32'h7F80);
    checkVal("t5_mem5", {16'd0, memModel[5]}, 32'h05FA);
    checkVal("t5_addr_wrap", {25'd0, imem_addr}, 32'd0);
    checkVal("t5_done_count", doneCount, 32'd1);

    // Reset while waiting for a lo byte, junk, then a one-word frame.
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h02);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33);
    rst = 1'b0;
    @(negedge clk);
    checkVal("t6_rst_hold", {31'd0, cpu_hold}, 32'd1);
    checkVal("t6_rst_addr", {25'd0, imem_addr}, 32'd0);
    checkVal("t6_rst_we", {31'd0, imem_we}, 32'd0);
    checkVal("t6_rst_ready", {31'd0, in_ready}, 32'd1);
    checkVal("t6_rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    clearStats();
    sendByte(8'h00); sendByte(8'hFF);
    sendByte(8'hA5); sendByte(8'h00); sendByte(8'h01);
    sendByte(8'hC3); sendByte(8'h3C);
    sendCsum(8'hFF);
    repeat (3) @(negedge clk);
    checkVal("t6_we_count", weCount, 32'd1);
    checkVal("t6_addr", {25'd0, lastAddr}, 32'd0);
    checkVal("t6_mem0", {16'd0, memModel[0]}, 32'hC33C);
    checkVal("t6_done_count", doneCount, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
